// File: rtl/xadc_avg_core.sv
// rtl/xadc_avg_core.sv - XADC DRP sequencer with per-channel raw/averaged results and alarms
module xadc_avg_core #(
    parameter int                  NUM_CH   = 6,
    parameter int                  AVG_LOG2 = 2,
    parameter logic [5*NUM_CH-1:0] CH_MAP   = {5'h01, 5'h00, 5'h1B, 5'h12, 5'h1A, 5'h13},
    parameter int                  TIMEOUT  = 255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cs,
    input  logic        read,
    input  logic        write,
    input  logic [4:0]  addr,
    input  logic [31:0] wr_data,
    output logic [31:0] rd_data,
    input  logic        eoc_in,
    input  logic [4:0]  channel_in,
    output logic [6:0]  daddr_out,
    output logic        den_out,
    input  logic        drdy_in,
    input  logic [15:0] do_in
);
    localparam int AW = 16 + AVG_LOG2;
    localparam int CW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CFULL = CW'((1 << AVG_LOG2) - 1);
    localparam logic [TW-1:0] TMAX  = TW'(TIMEOUT - 1);
    localparam logic [3:0]    NCH   = 4'(NUM_CH);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_UPDATE} state_t;

    state_t        state_q, state_d;
    logic [2:0]    idx_q, idx_d;
    logic [15:0]   data_q;
    logic          den_q, den_d;
    logic [6:0]    daddr_q, daddr_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic          tmo_q, tmo_d;
    logic [7:0]    alarm_q, alarm_d;

    // Arrays are sized for the maximum channel count; entries >= NUM_CH stay idle
    logic [15:0]   raw_q [8];
    logic [15:0]   avg_q [8];
    logic [AW-1:0] acc_q [8];
    logic [CW-1:0] cnt_q [8];
    logic [15:0]   thr_q [8];

    logic          hit, capture, tmo_set, upd, full;
    logic [2:0]    hit_idx;
    logic [AW-1:0] sum;
    logic          wr_en, alarm_wr, tmo_wr, thr_wr, rd_ok;
    logic          unused_ok;

    assign unused_ok = ^{read, wr_data[31:16]};
    assign den_out   = den_q;
    assign daddr_out = daddr_q;

    assign wr_en    = cs & write;
    assign rd_ok    = ({1'b0, addr[2:0]} < NCH);
    assign alarm_wr = wr_en && (addr == 5'd16);
    assign tmo_wr   = wr_en && (addr == 5'd17);
    assign thr_wr   = wr_en && (addr[4:3] == 2'b11) && rd_ok;

    // Descending scan so the lowest matching slice is the one left in hit_idx
    always_comb begin
        hit     = 1'b0;
        hit_idx = 3'd0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (CH_MAP[5*i +: 5] == channel_in) begin
                hit     = 1'b1;
                hit_idx = 3'(i);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        den_d   = 1'b0;
        daddr_d = daddr_q;
        tmr_d   = tmr_q;
        tmo_set = 1'b0;
        capture = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (eoc_in && hit) begin
                    idx_d   = hit_idx;
                    den_d   = 1'b1;
                    daddr_d = {2'b00, channel_in};
                    tmr_d   = '0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (drdy_in) begin
                    capture = 1'b1;
                    state_d = S_UPDATE;
                end else if (tmr_q == TMAX) begin
                    tmo_set = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    tmr_d = tmr_q + TW'(1);
                end
            end
            S_UPDATE: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    assign upd  = (state_q == S_UPDATE);
    assign sum  = acc_q[idx_q] + AW'(data_q);
    assign full = (cnt_q[idx_q] == CFULL);

    // Clear is applied first so a same-cycle set survives
    always_comb begin
        alarm_d = alarm_q & ~(alarm_wr ? wr_data[7:0] : 8'h00);
        if (upd && (data_q > thr_q[idx_q]))
            alarm_d = alarm_d | (8'h01 << idx_q);
        tmo_d = (tmo_q & ~(tmo_wr & wr_data[0])) | tmo_set;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            idx_q   <= 3'd0;
            data_q  <= 16'h0;
            den_q   <= 1'b0;
            daddr_q <= 7'h0;
            tmr_q   <= '0;
            tmo_q   <= 1'b0;
            alarm_q <= 8'h0;
            for (int i = 0; i < 8; i++) begin
                raw_q[i] <= 16'h0;
                avg_q[i] <= 16'h0;
                acc_q[i] <= '0;
                cnt_q[i] <= '0;
                thr_q[i] <= 16'hFFFF;
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            den_q   <= den_d;
            daddr_q <= daddr_d;
            tmr_q   <= tmr_d;
            tmo_q   <= tmo_d;
            alarm_q <= alarm_d;
            if (capture)
                data_q <= do_in;
            if (thr_wr)
                thr_q[addr[2:0]] <= wr_data[15:0];
            if (upd) begin
                raw_q[idx_q] <= data_q;
                if (full) begin
                    avg_q[idx_q] <= 16'(sum >> AVG_LOG2);
                    acc_q[idx_q] <= '0;
                    cnt_q[idx_q] <= '0;
                end else begin
                    acc_q[idx_q] <= sum;
                    cnt_q[idx_q] <= cnt_q[idx_q] + CW'(1);
                end
            end
        end
    end

    always_comb begin
        rd_data = 32'h0;
        case (addr[4:3])
            2'b00: if (rd_ok) rd_data = {16'h0, avg_q[addr[2:0]]};
            2'b01: if (rd_ok) rd_data = {16'h0, raw_q[addr[2:0]]};
            2'b10: begin
                if (addr[2:0] == 3'd0) rd_data = {24'h0, alarm_q};
                if (addr[2:0] == 3'd1) rd_data = {31'h0, tmo_q};
            end
            default: if (rd_ok) rd_data = {16'h0, thr_q[addr[2:0]]};
        endcase
    end
endmodule

// File: tb/tb_xadc_avg_core.sv
// tb/tb_xadc_avg_core.sv - directed scoreboard bench for xadc_avg_core
module tb_xadc_avg_core;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cs = 1'b0, read = 1'b0, write = 1'b0;
    logic [4:0]  addr = 5'd0;
    logic [31:0] wr_data = 32'h0;
    logic [31:0] rd_data, rd_data2;
    logic        eoc = 1'b0, eoc2 = 1'b0;
    logic [4:0]  channel = 5'd0, channel2 = 5'd0;
    logic [6:0]  daddr, daddr2;
    logic        den, den2;
    logic        drdy = 1'b0, drdy2 = 1'b0;
    logic [15:0] do_in = 16'h0, do_in2 = 16'h0;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q [$];

    always #5 clk = ~clk;

    xadc_avg_core u_dut (
        .clk(clk), .reset_n(reset_n), .cs(cs), .read(read), .write(write),
        .addr(addr), .wr_data(wr_data), .rd_data(rd_data),
        .eoc_in(eoc), .channel_in(channel), .daddr_out(daddr), .den_out(den),
        .drdy_in(drdy), .do_in(do_in)
    );

    xadc_avg_core #(.NUM_CH(2), .AVG_LOG2(0), .CH_MAP({5'h12, 5'h13})) u_dut2 (
        .clk(clk), .reset_n(reset_n), .cs(cs), .read(read), .write(write),
        .addr(addr), .wr_data(wr_data), .rd_data(rd_data2),
        .eoc_in(eoc2), .channel_in(channel2), .daddr_out(daddr2), .den_out(den2),
        .drdy_in(drdy2), .do_in(do_in2)
    );

    task automatic check(input string tag, input logic [31:0] obs);
        logic [31:0] expv;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL %s: observed %h expected <none queued>", tag, obs);
        end else begin
            expv = exp_q.pop_front();
            assert (obs === expv) else begin
                errors++;
                $error("FAIL %s: observed %h expected %h", tag, obs, expv);
            end
        end
    endtask

    task automatic rd(input logic [4:0] a, input logic [31:0] e, input string tag, input bit second = 1'b0);
        @(negedge clk);
        exp_q.push_back(e);
        addr = a; cs = 1'b1; read = 1'b1;
        #1;
        check(tag, second ? rd_data2 : rd_data);
        cs = 1'b0; read = 1'b0;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        cs = 1'b1; write = 1'b1; addr = a; wr_data = d;
        @(negedge clk);
        cs = 1'b0; write = 1'b0;
    endtask

    task automatic conv(input logic [4:0] ch, input logic [15:0] d, input bit w1c);
        @(negedge clk);
        eoc = 1'b1; channel = ch;
        exp_q.push_back(32'd1);
        exp_q.push_back(32'(ch));
        @(negedge clk);
        eoc = 1'b0;
        check("den_hi", 32'(den));
        check("daddr", 32'(daddr));
        @(negedge clk);
        exp_q.push_back(32'd0);
        check("den_lo", 32'(den));
        drdy = 1'b1; do_in = d;
        @(negedge clk);
        drdy = 1'b0;
        if (w1c) begin
            cs = 1'b1; write = 1'b1; addr = 5'd16; wr_data = 32'h10;
        end
        @(negedge clk);
        cs = 1'b0; write = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        rd(5'd0,  32'h0,    "rst_avg0");
        rd(5'd24, 32'hFFFF, "rst_thr0");

        conv(5'h13, 16'd100, 1'b0);
        conv(5'h13, 16'd200, 1'b0);
        conv(5'h13, 16'd300, 1'b0);
        rd(5'd0, 32'd0,   "avg_pre4");
        rd(5'd8, 32'd300, "raw_3rd");
        conv(5'h13, 16'd400, 1'b0);
        rd(5'd0, 32'd250, "avg_4");
        rd(5'd8, 32'd400, "raw_4th");

        @(negedge clk);
        eoc = 1'b1; channel = 5'h05;
        @(negedge clk);
        eoc = 1'b0;
        exp_q.push_back(32'd0);
        check("unmatched_den0", 32'(den));
        @(negedge clk);
        exp_q.push_back(32'd0);
        check("unmatched_den1", 32'(den));
        rd(5'd0, 32'd250, "unmatched_avg0");
        rd(5'd8, 32'd400, "unmatched_raw0");

        wr(5'd28, 32'h8000);
        rd(5'd28, 32'h8000, "thr4");
        conv(5'h00, 16'h8001, 1'b0);
        rd(5'd16, 32'h10, "alarm_set");
        wr(5'd16, 32'h10);
        rd(5'd16, 32'h0, "alarm_clr");
        conv(5'h00, 16'h8000, 1'b0);
        rd(5'd16, 32'h0, "alarm_equal");
        conv(5'h00, 16'h8001, 1'b1);
        rd(5'd16, 32'h10, "alarm_set_wins");
        conv(5'h00, 16'h8001, 1'b0);
        rd(5'd4,  32'h8000, "avg4");
        rd(5'd12, 32'h8001, "raw4");

        @(negedge clk);
        eoc = 1'b1; channel = 5'h1A;
        @(negedge clk);
        eoc = 1'b0;
        repeat (253) @(negedge clk);
        rd(5'd17, 32'h0, "tmo_not_yet");
        rd(5'd17, 32'h1, "tmo_set");
        rd(5'd1,  32'h0, "tmo_avg1");
        rd(5'd9,  32'h0, "tmo_raw1");
        wr(5'd17, 32'h1);
        rd(5'd17, 32'h0, "tmo_clr");
        conv(5'h1A, 16'h0042, 1'b0);
        rd(5'd9, 32'h42, "post_tmo_raw1");

        @(negedge clk);
        eoc = 1'b1; channel = 5'h13;
        @(negedge clk);
        eoc = 1'b0;
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1; drdy = 1'b1; do_in = 16'h1234;
        @(negedge clk);
        drdy = 1'b0;
        exp_q.push_back(32'd0);
        check("rst_den", 32'(den));
        exp_q.push_back(32'd0);
        check("rst_daddr", 32'(daddr));
        rd(5'd0,  32'h0,    "rst2_avg0");
        rd(5'd8,  32'h0,    "rst2_raw0");
        rd(5'd12, 32'h0,    "rst2_raw4");
        rd(5'd16, 32'h0,    "rst2_alarm");
        rd(5'd28, 32'hFFFF, "rst2_thr4");
        rd(5'd30, 32'h0,    "rst2_thr6_absent");

        @(negedge clk);
        eoc2 = 1'b1; channel2 = 5'h12;
        exp_q.push_back(32'd1);
        exp_q.push_back(32'h12);
        @(negedge clk);
        eoc2 = 1'b0;
        check("d2_den", 32'(den2));
        check("d2_daddr", 32'(daddr2));
        @(negedge clk);
        drdy2 = 1'b1; do_in2 = 16'hABCD;
        @(negedge clk);
        drdy2 = 1'b0;
        rd(5'd1, 32'hABCD, "d2_avg1", 1'b1);
        rd(5'd9, 32'hABCD, "d2_raw1", 1'b1);
        rd(5'd2, 32'h0,    "d2_avg2_absent", 1'b1);
        rd(5'd0, 32'h0,    "d2_avg0", 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/xadc_avg_core.md
Name: xadc_avg_core

Overview:
Parametrised successor XADC slot core for the FPro bus. Sits between the XADC DRP port and an FPro slot. Features:
- Configurable channel count and channel map.
- DRP read sequencing via FSM with drdy timeout.
- Per-channel raw and 2^AVG_LOG2 boxcar-averaged results.
- Per-channel software-programmable over-threshold sticky alarms.

Parameters:
NUM_CH, 6, number of logical channels (1..8)
AVG_LOG2, 2, log2 of samples per average (0..6); 0 means avg equals raw
CH_MAP, {5'h01,5'h00,5'h1B,5'h12,5'h1A,5'h13}, packed 5*NUM_CH bits; slice i is the XADC channel address of logical channel i (slice 0 = LSBs)
TIMEOUT, 255, max cycles to wait for drdy_in after den_out

Ports:
clk  in  1  system clock; also the DRP clock
reset_n  in  1  synchronous, active-low reset
cs  in  1  slot chip select
read  in  1  slot read strobe (reads are side-effect free)
write  in  1  slot write strobe; effective only when cs=1
addr  in  5  slot register address
wr_data  in  32  write data
rd_data  out  32  combinational read data
eoc_in  in  1  XADC end-of-conversion pulse
channel_in  in  5  XADC channel_out
daddr_out  out  7  DRP address
den_out  out  1  DRP enable, one-cycle pulse
drdy_in  in  1  DRP data ready
do_in  in  16  DRP read data

Behaviour:
- Reset is sampled on the clk edge with reset_n=0. It clears state to IDLE, den_out=0, daddr_out=0, and all raw/avg/acc/count registers to 0. Alarm bits and the timeout flag are cleared. Thresholds are set to 16'hFFFF. Reset applied mid-WAIT abandons the transaction; a late drdy_in is ignored.
- FSM states: IDLE, WAIT, UPDATE.
- IDLE:
  - eoc_in=1 and channel_in equals CH_MAP slice i: latch i and data channel, assert den_out for exactly the next cycle with daddr_out={2'b00,channel_in}, go to WAIT.
  - If multiple slices match, the lowest i wins.
  - Unmatched channel: remain in IDLE, no den_out.
- WAIT:
  - drdy_in=1: capture do_in, go to UPDATE.
  - Timer counts cycles in WAIT. If TIMEOUT cycles pass with no drdy_in: set sticky timeout flag, go to IDLE, update nothing.
  - eoc_in is ignored outside IDLE (dropped; no queueing).
- UPDATE (1 cycle, then IDLE):
  - raw[i] <= data.
  - acc[i] (16+AVG_LOG2 bits) accumulates data.
  - cnt[i] (AVG_LOG2 bits) increments. When cnt[i] was 2^AVG_LOG2-1: avg[i] <= (acc[i]+data)>>AVG_LOG2 (truncating), acc[i] <= 0, cnt wraps to 0.
  - If data > thr[i] (unsigned, strict): alarm[i] <= 1.
- Latency: drdy_in sampled at edge m → raw visible on rd_data after edge m+1. Minimum eoc-to-eoc service time is 3 cycles plus DRP latency.
- Register map (rd_data upper unused bits = 0):
  - addr 0..7 (R): {16'h0, avg[i]}.
  - addr 8..15 (R): {16'h0, raw[i-8]}.
  - addr 16 (R/W1C): alarm[NUM_CH-1:0]. A write with wr_data bit k=1 clears alarm[k].
  - addr 17 (R/W1C): bit0 = timeout flag.
  - addr 24..31 (R/W): thr[i-24] = wr_data[15:0].
  - Indices i>=NUM_CH read 0 and ignore writes. Other addresses read 0.
- Simultaneous events:
  - Alarm set and W1C in the same cycle: set wins.
  - Timeout set and clear in the same cycle: set wins.
  - Threshold write in the same cycle as UPDATE: compare uses the old threshold.

Test Plan:
- Default params, 4 conversions on ch 0x13 with do_in=100,200,300,400 (drdy 2 cycles after den) → den_out pulses each 1 cycle, daddr_out=7'h13; addr0 reads 250 after the 4th; addr8 reads 400; avg stays 0 before the 4th.
- eoc_in with channel_in=5'h05 → den_out never asserts; all registers unchanged.
- Write addr 28 = 16'h8000; conversion ch 0x00 with do_in=16'h8001 → addr16 bit4=1. do_in=16'h8000 → no alarm. Write addr16=32'h10 → bit4 clears. Set and clear in the same cycle → bit stays 1.
- eoc on ch 0x1A, no drdy_in for 255 cycles → FSM back in IDLE, addr17=1, addr1/addr9 unchanged. Write addr17=1 → addr17=0.
- reset_n=0 for one cycle while in WAIT, then drdy_in=1 with do_in=16'h1234 → ignored; all reads 0; thresholds read 16'hFFFF.
- AVG_LOG2=0, NUM_CH=2: single sample 16'hABCD on ch 0x12 (slice 1) → addr1 and addr9 both read 16'hABCD; addr2 reads 0.
